// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle for the hazard/stall controller: hazard operands in,
// stage-register enables/clears and statistics out.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             fwd_en;
    logic [3:0]       id_src_1;
    logic [3:0]       id_src_2;
    logic             id_two_src;
    logic [3:0]       ex_dst;
    logic             ex_wb_en;
    logic             ex_mem_r_en;
    logic [3:0]       mem_dst;
    logic             mem_wb_en;
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken;
    logic             freeze_if;
    logic             bubble_ex;
    logic             freeze_all;
    logic             flush;
    logic [CNT_W-1:0] stall_count;
    logic             timeout_err;

    modport master (
        output fwd_en, id_src_1, id_src_2, id_two_src, ex_dst, ex_wb_en,
               ex_mem_r_en, mem_dst, mem_wb_en, mem_req, mem_ready, branch_taken,
        input  freeze_if, bubble_ex, freeze_all, flush, stall_count, timeout_err
    );

    modport slave (
        input  fwd_en, id_src_1, id_src_2, id_two_src, ex_dst, ex_wb_en,
               ex_mem_r_en, mem_dst, mem_wb_en, mem_req, mem_ready, branch_taken,
        output freeze_if, bubble_ex, freeze_all, flush, stall_count, timeout_err
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencing for the 5-stage core: RAW stall with bubble,
// whole-pipe freeze on SRAM wait with timeout, and branch flush.
//
// state    | meaning
// RUN      | normal flow; may stall, flush, or freeze on a same-cycle SRAM miss
// MEM_WAIT | SRAM access outstanding; whole pipeline frozen
// ERR      | SRAM never answered; frozen until reset
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_stall_controller_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_left;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              timeout_err_q;

    logic match_ex;
    logic match_mem;
    logic raw;
    logic mem_hold;
    logic freeze_all_c;
    logic flush_c;
    logic stall_c;

    always_comb begin
        match_ex  = (bus.ex_dst == bus.id_src_1) ||
                    (bus.id_two_src && (bus.ex_dst == bus.id_src_2));
        match_mem = (bus.mem_dst == bus.id_src_1) ||
                    (bus.id_two_src && (bus.mem_dst == bus.id_src_2));
        if (bus.fwd_en)
            raw = bus.ex_wb_en & bus.ex_mem_r_en & match_ex;
        else
            raw = (bus.ex_wb_en & match_ex) | (bus.mem_wb_en & match_mem);

        mem_hold = (state == MEM_WAIT) || (state == ERR) ||
                   ((state == RUN) && bus.mem_req && !bus.mem_ready);

        // One action per cycle: memory freeze beats branch flush beats RAW stall.
        freeze_all_c = !rst && mem_hold;
        flush_c      = !rst && bus.branch_taken && !mem_hold;
        stall_c      = !rst && raw && !mem_hold && !bus.branch_taken;
    end

    assign bus.freeze_all  = freeze_all_c;
    assign bus.flush       = flush_c;
    assign bus.freeze_if   = stall_c;
    assign bus.bubble_ex   = stall_c;
    assign bus.stall_count = rst ? '0 : stall_cnt_q;
    assign bus.timeout_err = rst ? 1'b0 : timeout_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            wait_left     <= '0;
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if ((freeze_all_c || stall_c) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;

            // wait_left counts down the MEM_WAIT cycles still allowed.
            case (state)
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        state     <= MEM_WAIT;
                        wait_left <= WAIT_LOAD;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state <= RUN;
                    end else if (wait_left == '0) begin
                        state         <= ERR;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_left <= wait_left - 1'b1;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end
endmodule
